// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state ring counter plus opcode decode into the 12-bit control word.
// Latency: ring advances once per CLK falling edge; CON is combinational from T, opcode and halt flag.
// Backpressure: none; HLT_bar low freezes the ring at T4 until CLR and is used to gate the clock source.
module sap1_controller_sequencer (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [3:0]  opcode,
    output logic [11:0] CON,
    output logic [5:0]  T,
    output logic        HLT_bar
);

    // One-hot ring states; the encoding is the T output directly.
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    // Control word bit order: Cp Ep L_M_bar CE_bar L_I_bar E_I_bar L_A_bar E_A S_U E_U L_B_bar L_O_bar
    localparam logic [11:0] CON_NOP     = 12'h3E3;
    localparam logic [11:0] CON_FETCH_1 = 12'h5E3;
    localparam logic [11:0] CON_FETCH_2 = 12'hBE3;
    localparam logic [11:0] CON_FETCH_3 = 12'h263;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    ring_t state;
    ring_t state_nxt;
    logic  halted;
    logic  halted_nxt;

    // Ring and halt flag change on the falling edge so CON is settled before the datapath's rising edge.
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            state  <= T1;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= halted_nxt;
        end
    end

    // Next-state logic and control-word decode.
    always_comb begin
        state_nxt  = state;
        halted_nxt = halted;
        CON        = CON_NOP;

        if (!halted) begin
            case (state)
                T1: state_nxt = T2;
                T2: state_nxt = T3;
                T3: state_nxt = T4;
                T4: begin
                    // HLT parks the ring in T4 rather than advancing.
                    if (opcode == OP_HLT) begin
                        halted_nxt = 1'b1;
                    end else begin
                        state_nxt = T5;
                    end
                end
                T5: state_nxt = T6;
                T6: state_nxt = T1;
                // Any non-one-hot value recovers to the start of fetch.
                default: state_nxt = T1;
            endcase

            case (state)
                T1: CON = CON_FETCH_1;
                T2: CON = CON_FETCH_2;
                T3: CON = CON_FETCH_3;
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: CON = 12'h1A3;
                        OP_OUT:                 CON = 12'h3F2;
                        default:                CON = CON_NOP;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         CON = 12'h2C3;
                        OP_ADD, OP_SUB: CON = 12'h2E1;
                        default:        CON = CON_NOP;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  CON = 12'h3C7;
                        OP_SUB:  CON = 12'h3CF;
                        default: CON = CON_NOP;
                    endcase
                end
                default: CON = CON_NOP;
            endcase
        end

        // Reset holds the datapath idle for its whole duration, independent of the ring.
        if (CLR) begin
            CON = CON_NOP;
        end
    end

    assign T       = state;
    assign HLT_bar = ~halted;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
module tb_sap1_controller_sequencer;

    logic        CLK;
    logic        CLR;
    logic [3:0]  opcode;
    logic [11:0] CON;
    logic [5:0]  T;
    logic        HLT_bar;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [3:0]  op;
        logic [11:0] e4;
        logic [11:0] e5;
        logic [11:0] e6;
    } vec_t;

    vec_t vecs [6];
    logic [11:0] fetch_words [3];

    sap1_controller_sequencer dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .opcode  (opcode),
        .CON     (CON),
        .T       (T),
        .HLT_bar (HLT_bar)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog: the bench must never hang.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Run nstates ring states of instruction v starting in T1; opcode holds a
    // junk value during fetch to show it is ignored there.
    task automatic run_instr(input vec_t v, input int nstates);
        logic [11:0] exp_con;
        logic [5:0]  exp_t;
        for (int k = 0; k < nstates; k++) begin
            opcode = (k < 3) ? ~v.op : v.op;
            #1;
            exp_t = 6'b000001 << k;
            case (k)
                0, 1, 2: exp_con = fetch_words[k];
                3:       exp_con = v.e4;
                4:       exp_con = v.e5;
                default: exp_con = v.e6;
            endcase
            chk($sformatf("op%h_T%0d_T", v.op, k + 1), {6'd0, T}, {6'd0, exp_t});
            chk($sformatf("op%h_T%0d_CON", v.op, k + 1), CON, exp_con);
            chk($sformatf("op%h_T%0d_HLT_bar", v.op, k + 1), {11'd0, HLT_bar}, 12'd1);
            chk($sformatf("op%h_T%0d_onehot", v.op, k + 1), {11'd0, $onehot(T)}, 12'd1);
            @(negedge CLK);
            #1;
        end
    endtask

    // Release reset while CLK is low so the next rising edge sees the T1 word.
    task automatic release_reset(input string name);
        @(negedge CLK);
        #2;
        CLR = 1'b0;
        #1;
        chk({name, "_rel_CON"}, CON, 12'h5E3);
        chk({name, "_rel_T"}, {6'd0, T}, 12'h001);
        @(negedge CLK);
        #1;
        chk({name, "_first_edge_T"}, {6'd0, T}, 12'h002);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        fetch_words[0] = 12'h5E3;
        fetch_words[1] = 12'hBE3;
        fetch_words[2] = 12'h263;

        vecs[0] = '{op: 4'h0, e4: 12'h1A3, e5: 12'h2C3, e6: 12'h3E3}; // LDA
        vecs[1] = '{op: 4'h1, e4: 12'h1A3, e5: 12'h2E1, e6: 12'h3C7}; // ADD
        vecs[2] = '{op: 4'h2, e4: 12'h1A3, e5: 12'h2E1, e6: 12'h3CF}; // SUB
        vecs[3] = '{op: 4'hE, e4: 12'h3F2, e5: 12'h3E3, e6: 12'h3E3}; // OUT
        vecs[4] = '{op: 4'h5, e4: 12'h3E3, e5: 12'h3E3, e6: 12'h3E3}; // undefined
        vecs[5] = '{op: 4'hF, e4: 12'h3E3, e5: 12'h3E3, e6: 12'h3E3}; // HLT

        // Reset state while CLR is held.
        CLR    = 1'b1;
        opcode = 4'h0;
        #3;
        chk("reset_T", {6'd0, T}, 12'h001);
        chk("reset_CON", CON, 12'h3E3);
        chk("reset_HLT_bar", {11'd0, HLT_bar}, 12'd1);

        // Come out of reset: T1 word immediately; the first falling edge then
        // reaches T2, so restart a clean reset for the table from T1.
        release_reset("init");
        CLR = 1'b1;
        #1;
        chk("init_reclear_T", {6'd0, T}, 12'h001);
        @(negedge CLK);
        #2;
        CLR = 1'b0;
        #1;

        // Table: LDA, ADD, SUB, OUT and undefined opcode, each a full 6-state instruction.
        for (int i = 0; i < 5; i++) begin
            run_instr(vecs[i], 6);
        end
        // Ring wrapped back to T1 after the last instruction.
        chk("wrap_T", {6'd0, T}, 12'h001);

        // CLR in the middle of T5 of an ADD.
        run_instr(vecs[1], 4);
        chk("add_T5_CON", CON, 12'h2E1);
        @(posedge CLK);
        #1;
        CLR = 1'b1;
        #1;
        chk("midT5_clr_T", {6'd0, T}, 12'h001);
        chk("midT5_clr_CON", CON, 12'h3E3);
        chk("midT5_clr_HLT_bar", {11'd0, HLT_bar}, 12'd1);
        @(negedge CLK);
        #1;
        chk("clr_held_T", {6'd0, T}, 12'h001);
        chk("clr_held_CON", CON, 12'h3E3);
        #1;
        CLR = 1'b0;
        #1;
        chk("midT5_rel_CON", CON, 12'h5E3);
        @(negedge CLK);
        #1;
        chk("midT5_rel_T2", {6'd0, T}, 12'h002);
        CLR = 1'b1;
        #1;
        @(negedge CLK);
        #2;
        CLR = 1'b0;
        #1;

        // Halt: fetch + T4 normally, then frozen at T4 regardless of opcode.
        run_instr(vecs[5], 3);
        opcode = 4'hF;
        #1;
        chk("hlt_T4_T", {6'd0, T}, 12'h008);
        chk("hlt_T4_CON", CON, 12'h3E3);
        chk("hlt_T4_HLT_bar", {11'd0, HLT_bar}, 12'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            opcode = i[3:0];
            #1;
            chk($sformatf("halt%0d_T", i), {6'd0, T}, 12'h008);
            chk($sformatf("halt%0d_CON", i), CON, 12'h3E3);
            chk($sformatf("halt%0d_HLT_bar", i), {11'd0, HLT_bar}, 12'd0);
        end

        // Only CLR leaves halt, and it acts immediately.
        CLR = 1'b1;
        #1;
        chk("halt_clr_T", {6'd0, T}, 12'h001);
        chk("halt_clr_HLT_bar", {11'd0, HLT_bar}, 12'd1);
        chk("halt_clr_CON", CON, 12'h3E3);
        @(negedge CLK);
        #2;
        CLR = 1'b0;
        #1;

        // Machine runs normally again after leaving halt.
        run_instr(vecs[2], 6);
        chk("post_halt_wrap_T", {6'd0, T}, 12'h001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
